// File: rtl/ysyx_20020207_mem_arbiter.sv
// ysyx_20020207_mem_arbiter
// Shares the single memory port between the fetch unit (IFU, read-only) and
// the load/store unit (LSU). One transaction is in flight at a time:
// IDLE (grant) -> REQ (drive memory) -> WAIT (await response / timeout)
// -> RESP (one-cycle pulse to owner) -> IDLE.
//
// Ports
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_ifu_req_valid/i_ifu_addr  IFU read request, held until o_ifu_req_ready
//   o_ifu_req_ready             one-cycle accept pulse to IFU
//   o_ifu_resp_valid/o_ifu_rdata/o_ifu_resp_err  one-cycle IFU response
//   i_lsu_req_valid/i_lsu_addr/i_lsu_wen/i_lsu_wdata/i_lsu_wmask  LSU request
//   o_lsu_req_ready             one-cycle accept pulse to LSU
//   o_lsu_resp_valid/o_lsu_rdata/o_lsu_resp_err  one-cycle LSU response
//   o_mem_req_valid/i_mem_req_ready  request handshake to memory
//   o_mem_addr/o_mem_wen/o_mem_wdata/o_mem_wmask  latched request payload
//   i_mem_resp_valid/i_mem_rdata/i_mem_resp_err  memory response
//   o_owner                     0=IFU, 1=LSU; valid while o_busy
//   o_busy                      high whenever the FSM is not idle
module ysyx_20020207_mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_ifu_req_valid,
  output logic                  o_ifu_req_ready,
  input  logic [DATA_WIDTH-1:0] i_ifu_addr,
  output logic                  o_ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] o_ifu_rdata,
  output logic                  o_ifu_resp_err,
  input  logic                  i_lsu_req_valid,
  output logic                  o_lsu_req_ready,
  input  logic [DATA_WIDTH-1:0] i_lsu_addr,
  input  logic                  i_lsu_wen,
  input  logic [DATA_WIDTH-1:0] i_lsu_wdata,
  input  logic [3:0]            i_lsu_wmask,
  output logic                  o_lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] o_lsu_rdata,
  output logic                  o_lsu_resp_err,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_wen,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_wmask,
  input  logic                  i_mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_resp_err,
  output logic                  o_owner,
  output logic                  o_busy
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W:0] TO_V = (CNT_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e                r_state;
  logic                  r_last;   // last winner: 0=IFU, 1=LSU
  logic                  r_owner;
  logic [DATA_WIDTH-1:0] r_addr;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_wmask;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_idle;
  logic                  w_grant_ifu;
  logic                  w_grant_lsu;
  logic [CNT_W:0]        w_cnt_nxt;
  logic                  w_timeout;
  logic                  w_resp;

  always_comb begin
    w_idle      = (r_state == StIdle) && !i_reset;
    // On a tie the requester that did not win last gets the grant.
    w_grant_lsu = w_idle && i_lsu_req_valid && (!i_ifu_req_valid || !r_last);
    w_grant_ifu = w_idle && i_ifu_req_valid && (!i_lsu_req_valid || r_last);
    w_cnt_nxt   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    // Fires in the WAIT cycle that completes TIMEOUT cycles of waiting.
    w_timeout   = (TIMEOUT != 0) && (w_cnt_nxt == TO_V);
    w_resp      = (r_state == StResp);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_last  <= 1'b0;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= 4'h0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_grant_ifu) begin
            r_owner <= 1'b0;
            r_last  <= 1'b0;
            r_addr  <= i_ifu_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= 4'hF;
            r_state <= StReq;
          end else if (w_grant_lsu) begin
            r_owner <= 1'b1;
            r_last  <= 1'b1;
            r_addr  <= i_lsu_addr;
            r_wen   <= i_lsu_wen;
            r_wdata <= i_lsu_wdata;
            r_wmask <= i_lsu_wmask;
            r_state <= StReq;
          end
        end
        StReq: begin
          if (i_mem_req_ready) begin
            r_cnt   <= '0;
            r_state <= StWait;
          end
        end
        StWait: begin
          r_cnt <= w_cnt_nxt[CNT_W-1:0];
          // A response arriving on the timeout cycle still wins.
          if (i_mem_resp_valid) begin
            r_rdata <= r_wen ? '0 : i_mem_rdata;
            r_err   <= i_mem_resp_err;
            r_state <= StResp;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= StResp;
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    o_ifu_req_ready  = w_grant_ifu;
    o_lsu_req_ready  = w_grant_lsu;
    o_busy           = (r_state != StIdle);
    o_owner          = o_busy && r_owner;
    o_mem_req_valid  = (r_state == StReq);
    o_mem_addr       = r_addr;
    o_mem_wen        = r_wen;
    o_mem_wdata      = r_wdata;
    o_mem_wmask      = r_wmask;
    o_ifu_resp_valid = w_resp && !r_owner;
    o_lsu_resp_valid = w_resp && r_owner;
    o_ifu_rdata      = o_ifu_resp_valid ? r_rdata : '0;
    o_ifu_resp_err   = o_ifu_resp_valid && r_err;
    o_lsu_rdata      = o_lsu_resp_valid ? r_rdata : '0;
    o_lsu_resp_err   = o_lsu_resp_valid && r_err;
  end

endmodule

// File: tb/tb_ysyx_20020207_mem_arbiter.sv
// Self-checking bench for ysyx_20020207_mem_arbiter. Inputs are driven #1
// after the rising edge; a single monitor samples on the falling edge,
// models round-robin arbitration, pushes the expected response of each
// accepted request into a scoreboard and pops it when a response pulses.
module tb_ysyx_20020207_mem_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ifu_v, lsu_v, lsu_wen;
  logic [DW-1:0] ifu_addr, lsu_addr, lsu_wdata;
  logic [3:0]    lsu_wmask;
  logic          mem_req_ready, mem_resp_valid, mem_resp_err;
  logic [DW-1:0] mem_rdata;
  logic          o_ifu_req_ready, o_ifu_resp_valid, o_ifu_resp_err;
  logic          o_lsu_req_ready, o_lsu_resp_valid, o_lsu_resp_err;
  logic [DW-1:0] o_ifu_rdata, o_lsu_rdata, o_mem_addr, o_mem_wdata;
  logic          o_mem_req_valid, o_mem_wen, o_owner, o_busy;
  logic [3:0]    o_mem_wmask;

  ysyx_20020207_mem_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_ifu_req_valid(ifu_v), .o_ifu_req_ready(o_ifu_req_ready), .i_ifu_addr(ifu_addr),
    .o_ifu_resp_valid(o_ifu_resp_valid), .o_ifu_rdata(o_ifu_rdata),
    .o_ifu_resp_err(o_ifu_resp_err),
    .i_lsu_req_valid(lsu_v), .o_lsu_req_ready(o_lsu_req_ready), .i_lsu_addr(lsu_addr),
    .i_lsu_wen(lsu_wen), .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
    .o_lsu_resp_valid(o_lsu_resp_valid), .o_lsu_rdata(o_lsu_rdata),
    .o_lsu_resp_err(o_lsu_resp_err),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(mem_req_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
    .o_mem_wmask(o_mem_wmask),
    .i_mem_resp_valid(mem_resp_valid), .i_mem_rdata(mem_rdata), .i_mem_resp_err(mem_resp_err),
    .o_owner(o_owner), .o_busy(o_busy)
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event not expected or never seen (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    bit          owner;
    logic [31:0] rdata;
    bit          err;
  } resp_t;
  resp_t exp_q[$];
  bit    grant_log[$];

  // Current transaction as the bench model sees it.
  bit            txn_active = 0;
  bit            last_win = 0;
  bit            cur_owner, cur_wen, cur_err;
  logic [DW-1:0] cur_addr, cur_wdata, cur_rdata;
  logic [3:0]    cur_wmask;
  int            cur_stall = 0, cur_lat = 0, req_cnt = 0, resp_count = 0;
  longint        resp_at = -1, exp_resp_cyc = 0;
  longint        last_acc_cyc = 0, last_hs_cyc = 0, last_resp_cyc = 0;

  // Optional fixed memory behaviour for the next accepted request.
  bit            force_en = 0;
  int            f_stall, f_lat;
  bit            f_err;
  logic [DW-1:0] f_rdata;

  bit    win;
  resp_t e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_win   = 0;
      txn_active = 0;
      resp_at    = -1;
    end else begin
      if (o_ifu_req_ready || o_lsu_req_ready) begin
        if (!ifu_v && !lsu_v) chk("spurious_ready", {o_ifu_req_ready, o_lsu_req_ready}, 0);
        win = (ifu_v && lsu_v) ? !last_win : lsu_v;
        chk("grant_lsu", o_lsu_req_ready, win);
        chk("grant_ifu", o_ifu_req_ready, !win);
        chk("accept_while_busy", txn_active, 0);
        last_win = win;
        grant_log.push_back(win);
        last_acc_cyc = cyc;
        cur_owner = win;
        cur_addr  = win ? lsu_addr : ifu_addr;
        cur_wen   = win ? lsu_wen : 1'b0;
        cur_wdata = win ? lsu_wdata : '0;
        cur_wmask = win ? lsu_wmask : 4'hF;
        if (force_en) begin
          cur_stall = f_stall; cur_lat = f_lat; cur_err = f_err; cur_rdata = f_rdata;
          force_en = 0;
        end else begin
          cur_stall = $urandom_range(0, 3);
          cur_lat   = $urandom_range(1, TO + 2);
          cur_err   = ($urandom_range(0, 7) == 0);
          cur_rdata = $urandom;
        end
        e.owner = win;
        if (cur_lat > TO) begin
          e.rdata = '0; e.err = 1;
        end else begin
          e.rdata = cur_wen ? '0 : cur_rdata; e.err = cur_err;
        end
        exp_q.push_back(e);
        txn_active = 1;
        req_cnt    = 0;
      end
      if (o_mem_req_valid) begin
        if (!txn_active) chk("mem_req_unexpected", o_mem_req_valid, 0);
        else begin
          chk("mem_addr", o_mem_addr, cur_addr);
          chk("mem_wen", o_mem_wen, cur_wen);
          chk("mem_wdata", o_mem_wdata, cur_wdata);
          chk("mem_wmask", o_mem_wmask, cur_wmask);
          chk("owner", o_owner, cur_owner);
          if (mem_req_ready) begin
            last_hs_cyc  = cyc;
            resp_at      = cyc + cur_lat;
            exp_resp_cyc = cyc + ((cur_lat <= TO) ? cur_lat : TO) + 1;
          end else req_cnt++;
        end
      end
      if (o_ifu_resp_valid || o_lsu_resp_valid) begin
        chk("resp_both", o_ifu_resp_valid & o_lsu_resp_valid, 0);
        if (exp_q.size() == 0) fail_now("resp_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("resp_owner", o_lsu_resp_valid, e.owner);
          chk("resp_rdata", e.owner ? o_lsu_rdata : o_ifu_rdata, e.rdata);
          chk("resp_err", e.owner ? o_lsu_resp_err : o_ifu_resp_err, e.err);
          chk("nonowner_zero", e.owner ? {o_ifu_rdata, o_ifu_resp_err}
                                       : {o_lsu_rdata, o_lsu_resp_err}, 0);
          chk("resp_cycle", cyc, exp_resp_cyc);
        end
        txn_active = 0;
        last_resp_cyc = cyc;
        resp_count++;
      end
    end
  end

  // Memory model: stalls ready for cur_stall REQ cycles, responds cur_lat
  // cycles after the handshake (late responses on timeout are harmless).
  initial begin
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0; mem_resp_err = 0;
    forever begin
      @(posedge clk); #1;
      mem_req_ready = o_mem_req_valid && txn_active && (req_cnt >= cur_stall);
      if (cyc == resp_at) begin
        mem_resp_valid = 1; mem_rdata = cur_rdata; mem_resp_err = cur_err;
      end else begin
        mem_resp_valid = 0; mem_rdata = $urandom; mem_resp_err = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic set_force(input int s, input int l, input bit er, input logic [DW-1:0] d);
    f_stall = s; f_lat = l; f_err = er; f_rdata = d; force_en = 1;
  endtask

  task automatic ifu_req(input logic [DW-1:0] a);
    int n = 0;
    @(posedge clk); #1;
    ifu_v = 1; ifu_addr = a;
    @(negedge clk);
    while (!o_ifu_req_ready && n < 200) begin @(negedge clk); n++; end
    if (!o_ifu_req_ready) fail_now("ifu_ready_timeout");
    @(posedge clk); #1;
    ifu_v = 0; ifu_addr = $urandom;
  endtask

  task automatic lsu_req(input logic [DW-1:0] a, input bit w, input logic [DW-1:0] d,
                         input logic [3:0] m);
    int n = 0;
    @(posedge clk); #1;
    lsu_v = 1; lsu_addr = a; lsu_wen = w; lsu_wdata = d; lsu_wmask = m;
    @(negedge clk);
    while (!o_lsu_req_ready && n < 200) begin @(negedge clk); n++; end
    if (!o_lsu_req_ready) fail_now("lsu_ready_timeout");
    @(posedge clk); #1;
    lsu_v = 0; lsu_addr = $urandom; lsu_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((o_busy || exp_q.size() != 0) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) fail_now("idle_timeout");
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
  endtask

  int rc;
  logic [3:0] m;

  initial begin
    rst = 1; ifu_v = 0; lsu_v = 0; ifu_addr = '0; lsu_addr = '0;
    lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy_owner", {o_busy, o_owner}, 0);
    chk("rst_ready", {o_ifu_req_ready, o_lsu_req_ready}, 0);
    chk("rst_resp", {o_ifu_resp_valid, o_lsu_resp_valid, o_ifu_resp_err, o_lsu_resp_err}, 0);
    chk("rst_rdata", {o_ifu_rdata, o_lsu_rdata}, 0);
    chk("rst_mem_req", {o_mem_req_valid, o_mem_wen, o_mem_wmask}, 0);
    chk("rst_mem_payload", {o_mem_addr, o_mem_wdata}, 0);

    // IFU fetch, memory ready at once, data two cycles later.
    set_force(0, 2, 0, 32'h0000_0413);
    ifu_req(32'h8000_0000);
    wait_idle();
    chk("t1_accept_to_resp", last_resp_cyc - last_acc_cyc, 4);

    // Ties after reset: LSU, then IFU, then LSU again.
    do_reset();
    grant_log.delete();
    fork
      ifu_req(32'h8000_0010);
      lsu_req(32'h8000_2000, 0, 32'h0, 4'hF);
    join
    fork
      ifu_req(32'h8000_0014);
      lsu_req(32'h8000_2004, 1, 32'h1234_5678, 4'hF);
    join
    wait_idle();
    chk("t2_grant_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("t2_first_tie_lsu", grant_log[0], 1);
      chk("t2_then_ifu", grant_log[1], 0);
      chk("t2_second_tie_lsu", grant_log[2], 1);
      chk("t2_last_ifu", grant_log[3], 0);
    end

    // Byte store, memory stalls ready for 3 cycles.
    set_force(3, 2, 0, 32'hDEAD_BEEF);
    lsu_req(32'h8000_1003, 1, 32'h0000_00AB, 4'b0001);
    wait_idle();
    chk("t3_stall_span", last_hs_cyc - last_acc_cyc, 4);

    // Timeout: late response in RESP, late response in IDLE, response on the limit.
    set_force(0, TO + 1, 0, 32'h1234_5678);
    ifu_req(32'h8000_0020);
    wait_idle();
    chk("t4_timeout_span", last_resp_cyc - last_hs_cyc, TO + 1);
    set_force(0, TO + 2, 0, 32'h8765_4321);
    lsu_req(32'h8000_3000, 0, 32'h0, 4'hF);
    wait_idle();
    set_force(0, TO, 0, 32'hCAFE_0001);
    ifu_req(32'h8000_0024);
    wait_idle();

    // Reset while waiting for memory drops the transaction.
    set_force(0, 20, 0, 32'h5555_AAAA);
    rc = resp_count;
    ifu_req(32'h8000_0040);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("t5_busy_after_rst", o_busy, 0);
    chk("t5_no_resp", {o_ifu_resp_valid, o_lsu_resp_valid}, 0);
    repeat (30) @(negedge clk);
    chk("t5_dropped", resp_count - rc, 0);
    set_force(1, 1, 0, 32'h0000_0055);
    ifu_req(32'h8000_0044);
    wait_idle();
    chk("t5_served_after_rst", resp_count - rc, 1);

    // Load with memory error: data passes through with err set.
    set_force(1, 2, 1, 32'h0BAD_F00D);
    lsu_req(32'h8000_4000, 0, 32'h0, 4'hF);
    wait_idle();

    // Random traffic from both requesters.
    fork
      begin
        repeat (60) begin
          repeat ($urandom_range(0, 5)) @(posedge clk);
          ifu_req($urandom & 32'hFFFF_FFFC);
        end
      end
      begin
        repeat (60) begin
          repeat ($urandom_range(0, 5)) @(posedge clk);
          case ($urandom_range(0, 2))
            0:       m = 4'b0001;
            1:       m = 4'b0011;
            default: m = 4'b1111;
          endcase
          lsu_req($urandom, 1'($urandom_range(0, 1)), $urandom, m);
        end
      end
    join
    wait_idle();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
